// File: rtl/sd_load_sched.sv
// sd_load_sched: multi-sector load sequencer in front of the SD SPI read
// controller. A single start loads sec_cnt consecutive sectors, packs the
// 16-bit read stream into 32-bit words and writes them to model memory at
// incrementing word addresses, then pulses done (with an error class if a
// wait timed out or a sector delivered the wrong number of halfwords).
//
// Optional build macro SD_LOAD_SCHED_CHECKSUM_EN adds a 32-bit `checksum`
// output: the mod-2^32 sum of every word written during the current load.
module sd_load_sched #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       start_sec,
  input  logic [15:0]       sec_cnt,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              sd_init_done,
  output logic              rd_start_en,
  output logic [31:0]       rd_sec_addr,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [15:0]       rd_val_data,
`ifdef SD_LOAD_SCHED_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ERR_INIT = 2'b01;
  localparam logic [1:0] ERR_BUSY = 2'b10;
  localparam logic [1:0] ERR_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    ISSUE,
    WAIT_BUSY,
    XFER,
    NEXT,
    DONE,
    ERR
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                rd_start_en_q, rd_start_en_d;
  logic [31:0]         rd_sec_addr_q, rd_sec_addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          hw_cnt_q, hw_cnt_d;
  logic [15:0]         lo_q, lo_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                accept;
  logic                timeout;
  logic [8:0]          hw_inc;

  // A start is taken only in IDLE and never in the done-pulse cycle, so a
  // request that coincides with completion is dropped.
  assign accept  = (state_q == IDLE) && start && !done_q && !rst;
  assign timeout = (timer_q == TMR_W'(TIMEOUT_CYC));
  // Saturate so an overlong sector can never wrap back onto 256.
  assign hw_inc  = (hw_cnt_q == 9'h1FF) ? hw_cnt_q : hw_cnt_q + 9'd1;

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;
    rd_start_en_d = 1'b0;
    rd_sec_addr_d = rd_sec_addr_q;
    rem_d         = rem_q;
    addr_d        = addr_q;
    hw_cnt_d      = hw_cnt_q;
    lo_d          = lo_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rd_sec_addr_d = start_sec;
          rem_d         = sec_cnt;
          addr_d        = base_addr;
          err_d         = 1'b0;
          err_code_d    = 2'b00;
          busy_d        = 1'b1;
          state_d       = (sec_cnt == 16'd0) ? DONE : WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (sd_init_done) begin
          state_d = ISSUE;
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_INIT;
          state_d    = ERR;
        end
      end
      ISSUE: begin
        // A read left running (e.g. across a reset) must finish first.
        if (!rd_busy) begin
          rd_start_en_d = 1'b1;
          hw_cnt_d      = 9'd0;
          state_d       = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (rd_busy) begin
          state_d = XFER;
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_BUSY;
          state_d    = ERR;
        end
      end
      XFER: begin
        if (rd_val_en) begin
          hw_cnt_d = hw_inc;
          if (!hw_cnt_q[8]) begin
            if (!hw_cnt_q[0]) begin
              lo_d = rd_val_data;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = {rd_val_data, lo_q};
              addr_d      = addr_q + 1'b1;
            end
          end
        end
        // The count check sees a halfword arriving with the busy fall.
        if (!rd_busy) begin
          if (hw_cnt_d == 9'd256) begin
            state_d = NEXT;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_DATA;
            state_d    = ERR;
          end
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_DATA;
          state_d    = ERR;
        end
      end
      NEXT: begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = DONE;
        end else begin
          rd_sec_addr_d = rd_sec_addr_q + 32'd1;
          state_d       = ISSUE;
        end
      end
      DONE, ERR: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Idle-cycle timer restarts on any state change or data strobe.
    if ((state_d != state_q) || rd_val_en) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_ref) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      rd_start_en_q <= 1'b0;
      rd_sec_addr_q <= '0;
      rem_q         <= '0;
      addr_q        <= '0;
      hw_cnt_q      <= '0;
      lo_q          <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      rd_start_en_q <= rd_start_en_d;
      rd_sec_addr_q <= rd_sec_addr_d;
      rem_q         <= rem_d;
      addr_q        <= addr_d;
      hw_cnt_q      <= hw_cnt_d;
      lo_q          <= lo_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      timer_q       <= timer_d;
    end
  end

`ifdef SD_LOAD_SCHED_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum of written words, restarted by each accepted start.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (mem_we_q) begin
      checksum_q <= checksum_q + mem_wdata_q;
    end
  end

  assign checksum = checksum_q;
`endif

  // busy covers the accepting cycle itself, then follows the register.
  assign busy        = busy_q | accept;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign rd_start_en = rd_start_en_q;
  assign rd_sec_addr = rd_sec_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_sd_load_sched.sv
// tb_sd_load_sched: scoreboard bench for sd_load_sched. The stimulus pushes
// expected sector requests, memory writes and done results into queues; a
// monitor pops and compares whenever the DUT presents one of those events.
module tb_sd_load_sched;

  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_exp_t;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } done_exp_t;

  logic              clk_ref = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       start_sec;
  logic [15:0]       sec_cnt;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic              sd_init_done;
  logic              rd_start_en;
  logic [31:0]       rd_sec_addr;
  logic              rd_busy, rd_val_en;
  logic [15:0]       rd_val_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
`ifdef SD_LOAD_SCHED_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  sd_load_sched #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(64)) dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .start        (start),
    .start_sec    (start_sec),
    .sec_cnt      (sec_cnt),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .sd_init_done (sd_init_done),
    .rd_start_en  (rd_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .rd_busy      (rd_busy),
    .rd_val_en    (rd_val_en),
    .rd_val_data  (rd_val_data),
`ifdef SD_LOAD_SCHED_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

  always #5 clk_ref = ~clk_ref;

  int unsigned cyc = 0;
  always @(posedge clk_ref) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd_q[$];
  wr_exp_t     wr_q[$];
  done_exp_t   done_q[$];

  int          n_rd = 0, n_wr = 0, n_done = 0, busy_cnt = 0;
  int unsigned last_rd_cyc = 0;

  // SD model controls
  int next_base  = 0;
  int hw_per_sec = 256;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor / scoreboard: compare DUT events against the expected queues.
  initial begin
    forever begin
      @(negedge clk_ref);
      if (busy) busy_cnt++;
      if (rd_start_en) begin
        n_rd++;
        last_rd_cyc = cyc;
        check("rd_busy_low_at_issue", rd_busy, 0);
        check("rd_start_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rd_sec_addr", rd_sec_addr, rd_q.pop_front());
      end
      if (mem_we) begin
        n_wr++;
        check("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("mem_addr", mem_addr, w.addr);
          check("mem_wdata", mem_wdata, w.data);
        end
      end
      if (done) begin
        n_done++;
        check("busy_low_at_done", busy, 0);
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          done_exp_t d;
          d = done_q.pop_front();
          check("err_at_done", err, d.err);
          check("err_code_at_done", err_code, d.code);
        end
      end
    end
  end

  // SD read-controller model: busy rises one cycle after the request, then
  // hw_per_sec halfwords every other cycle counting up from next_base.
  initial begin
    int hb, n;
    rd_busy     = 1'b0;
    rd_val_en   = 1'b0;
    rd_val_data = '0;
    forever begin
      @(negedge clk_ref);
      if (rd_start_en) begin
        hb        = next_base;
        n         = hw_per_sec;
        next_base = next_base + n;
        @(posedge clk_ref); #1 rd_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(posedge clk_ref); #1 rd_val_en = 1'b1; rd_val_data = 16'(hb + i);
          @(posedge clk_ref); #1 rd_val_en = 1'b0;
        end
        @(posedge clk_ref); #1 rd_busy = 1'b0;
      end
    end
  end

  task automatic push_sector(input int addr, input int hb, input int nw);
    for (int k = 0; k < nw; k++) begin
      wr_q.push_back('{addr: ADDR_W'(addr + k),
                       data: {16'(hb + 2 * k + 1), 16'(hb + 2 * k)}});
    end
  endtask

  task automatic do_start(input logic [31:0] sec, input logic [15:0] cnt,
                          input logic [ADDR_W-1:0] base, output int unsigned st_cyc);
    @(posedge clk_ref); #1;
    start = 1'b1; start_sec = sec; sec_cnt = cnt; base_addr = base;
    st_cyc = cyc;
    @(posedge clk_ref); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int target;
    target = n_done + 1;
    for (int i = 0; i < budget && n_done < target; i++) @(posedge clk_ref);
    check("done_seen", n_done >= target, 1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget && n_wr < target; i++) @(posedge clk_ref);
    check("writes_reached", n_wr >= target, 1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_q_empty"}, rd_q.size(), 0);
    check({tag, "_wr_q_empty"}, wr_q.size(), 0);
    check({tag, "_done_q_empty"}, done_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_rd_start_en"}, rd_start_en, 0);
    check({tag, "_rd_sec_addr"}, rd_sec_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int unsigned st;
    int r0, w0, b0, d0;
    rst = 1'b1; start = 1'b0; start_sec = '0; sec_cnt = '0; base_addr = '0;
    sd_init_done = 1'b1;
    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    check_outputs_zero("reset");
    @(posedge clk_ref); #1 rst = 1'b0;

    // Two sectors, halfwords 0x0000..0x01FF.
    rd_q.push_back(32'h100);
    rd_q.push_back(32'h101);
    push_sector(16'h0040, 0, 128);
    push_sector(16'h00C0, 256, 128);
    done_q.push_back('{err: 1'b0, code: 2'b00});
    r0 = n_rd;
    do_start(32'h100, 16'd2, 16'h0040, st);
    for (int i = 0; i < 20 && n_rd == r0; i++) @(posedge clk_ref);
    check("start_to_rd_start_latency", last_rd_cyc - st, 3);
    wait_done(3000);
    repeat (4) @(posedge clk_ref);
    check_drained("two_sec");
    check("two_sec_writes", n_wr, 256);

    // Zero sectors: immediate done, no reads, no writes, busy two cycles.
    done_q.push_back('{err: 1'b0, code: 2'b00});
    b0 = busy_cnt; r0 = n_rd; w0 = n_wr;
    do_start(32'h55, 16'd0, 16'h0010, st);
    wait_done(20);
    repeat (3) @(posedge clk_ref);
    check("zero_sec_busy_cycles", busy_cnt - b0, 2);
    check("zero_sec_no_rd", n_rd - r0, 0);
    check("zero_sec_no_wr", n_wr - w0, 0);

    // Init never completes: init timeout.
    sd_init_done = 1'b0;
    done_q.push_back('{err: 1'b1, code: 2'b01});
    r0 = n_rd;
    do_start(32'h200, 16'd1, 16'h0000, st);
    wait_done(300);
    @(negedge clk_ref);
    check("init_to_err_sticky", err, 1);
    check("init_to_code_sticky", err_code, 2'b01);
    check("init_to_no_rd", n_rd - r0, 0);
    sd_init_done = 1'b1;

    // Next accepted start clears the sticky error.
    done_q.push_back('{err: 1'b0, code: 2'b00});
    do_start(32'h0, 16'd0, 16'h0000, st);
    @(negedge clk_ref);
    check("err_cleared_on_start", err, 0);
    wait_done(20);

    // Short sector: 255 halfwords -> 127 writes, data error, no second sector.
    hw_per_sec = 255;
    next_base  = 32'h4000;
    rd_q.push_back(32'h400);
    push_sector(16'h0600, 32'h4000, 127);
    done_q.push_back('{err: 1'b1, code: 2'b11});
    do_start(32'h400, 16'd2, 16'h0600, st);
    wait_done(1500);
    repeat (20) @(posedge clk_ref);
    check_drained("short_sec");
    hw_per_sec = 256;

    // Start ignored while busy, then reset mid-sector.
    next_base = 32'h2000;
    rd_q.push_back(32'h200);
    rd_q.push_back(32'h201);
    push_sector(16'h0100, 32'h2000, 128);
    w0 = n_wr;
    do_start(32'h200, 16'd2, 16'h0100, st);
    wait_writes(w0 + 10, 400);
    @(posedge clk_ref); #1;
    start = 1'b1; start_sec = 32'h777; sec_cnt = 16'd5; base_addr = 16'h0999;
    @(posedge clk_ref); #1 start = 1'b0;
    @(negedge clk_ref);
    check("ignored_start_sec_addr", rd_sec_addr, 32'h200);
    check("ignored_start_busy", busy, 1);
    wait_writes(w0 + 20, 400);
    d0 = n_done;
    @(posedge clk_ref); #1 rst = 1'b1;
    repeat (2) @(posedge clk_ref);
    @(negedge clk_ref);
    check_outputs_zero("mid_reset");
    @(posedge clk_ref); #1 rst = 1'b0;
    wr_q.delete();
    rd_q.delete();
    next_base = 32'h3000;
    rd_q.push_back(32'h300);
    push_sector(16'h0500, 32'h3000, 128);
    done_q.push_back('{err: 1'b0, code: 2'b00});
    do_start(32'h300, 16'd1, 16'h0500, st);
    wait_done(2000);
    repeat (4) @(posedge clk_ref);
    check("reset_no_done_pulse", n_done - d0, 1);
    check_drained("after_reset");

`ifdef SD_LOAD_SCHED_CHECKSUM_EN
    begin
      logic [31:0] cs;
      cs = '0;
      for (int k = 0; k < 128; k++) cs = cs + {16'(2 * k + 1), 16'(2 * k)};
      next_base = 0;
      rd_q.push_back(32'h10);
      push_sector(16'h0800, 0, 128);
      done_q.push_back('{err: 1'b0, code: 2'b00});
      do_start(32'h10, 16'd1, 16'h0800, st);
      wait_done(1000);
      check("checksum", checksum, cs);
      check_drained("checksum");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_load_sched.md
Name: sd_load_sched

Overview:
- Multi-sector load sequencer in front of the SD SPI read controller.
- On one start request it waits for card init, then issues consecutive single-sector reads (`rd_start_en`/`rd_sec_addr`) and packs the 16-bit read stream into 32-bit words.
- Packed words are written into on-chip model memory at incrementing addresses.
- Reports completion, or an error class on timeout or a short/long sector.

Parameters:
- ADDR_W, 16, memory word-address width; `mem_addr` wraps modulo 2^ADDR_W.
- TIMEOUT_CYC, 1048576, max idle cycles allowed in any wait state before error.

Ports:
- clk_ref  in  1  single clock, shared with SD controller.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- start_sec  in  32  first sector address, sampled on accepted start.
- sec_cnt  in  16  number of sectors, sampled on accepted start.
- base_addr  in  ADDR_W  first memory word address, sampled on accepted start.
- busy  out  1  high from accepted start until the cycle done pulses.
- done  out  1  one-cycle completion pulse (success or error).
- err  out  1  sticky error flag, cleared on next accepted start.
- err_code  out  2  00 none, 01 init timeout, 10 rd_busy-rise timeout, 11 data timeout or halfword-count mismatch.
- sd_init_done  in  1  SD card initialised.
- rd_start_en  out  1  one-cycle sector read request.
- rd_sec_addr  out  32  sector address; held stable from ISSUE through NEXT.
- rd_busy  in  1  SD read in progress.
- rd_val_en  in  1  rd_val_data valid strobe.
- rd_val_data  in  16  read halfword.
- mem_we  out  1  one-cycle write strobe; the memory always accepts it.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  packed word.

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE. Reset mid-transfer abandons the load with no done pulse.
- FSM states: IDLE, WAIT_INIT, ISSUE, WAIT_BUSY, XFER, NEXT, DONE, ERR.
- Timer: cleared on every state change and on every rd_val_en. Reaching TIMEOUT_CYC in WAIT_INIT, WAIT_BUSY or XFER goes to ERR with codes 01/10/11 respectively.
- IDLE:
  - start with busy=0 latches inputs, clears err/err_code, sets busy.
  - sec_cnt=0 goes straight to DONE, with no reads and no writes.
  - Otherwise goes to WAIT_INIT.
  - start while busy=1 is ignored.
- WAIT_INIT: advance to ISSUE when sd_init_done=1.
- ISSUE:
  - Waits while rd_busy=1 (covers a read left running after a reset).
  - Then drives rd_start_en=1 for exactly one cycle, clears the halfword counter, goes to WAIT_BUSY.
- WAIT_BUSY: advance to XFER on rd_busy=1.
- XFER:
  - Each rd_val_en increments the halfword counter (9 bits).
  - Even-count halfword is stored in mem_wdata[15:0]; the following odd-count halfword goes to [31:16].
  - mem_we pulses in the cycle after the odd-count rd_val_en, with mem_addr = current address; the address then increments.
  - Halfwords beyond 256 are counted but not written.
  - On rd_busy=0: count==256 goes to NEXT, any other count goes to ERR (11).
- NEXT:
  - Decrements remaining count.
  - Remaining zero goes to DONE; otherwise rd_sec_addr+1 and go to ISSUE.
  - rd_sec_addr wraps modulo 2^32.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- ERR: err=1 and err_code set, then behaves as DONE (done pulse, busy drops).
- Per sector: 128 writes; mem_addr after N sectors = base_addr + 128·N mod 2^ADDR_W.
- Latency: start to rd_start_en is 3 cycles when sd_init_done=1 and rd_busy=0.
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - rd_val_en in the same cycle as the rd_busy fall is counted before the count check.

Optional Feature:
- Macro: SD_LOAD_SCHED_CHECKSUM_EN.
- Defined: adds output `checksum` (32 bits).
  - Cleared on accepted start.
  - Adds each mem_wdata (mod 2^32) in the mem_we cycle.
  - Stable and valid when done pulses.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset with sd_init_done=1; start, start_sec=0x100, sec_cnt=2, base_addr=0x0040; model returns halfwords 0x0000..0x01FF
  -> rd_start_en with rd_sec_addr 0x100 then 0x101.
  -> 256 mem_we total; first write addr 0x0040 data 0x00010000; last write addr 0x013F data 0x01FF01FE.
  -> one done pulse, err=0.
- start with sec_cnt=0 -> done pulses; no rd_start_en, no mem_we; busy high for exactly 2 cycles.
- sd_init_done held 0, TIMEOUT_CYC=64 -> done with err=1, err_code=01, no rd_start_en.
- Model drops rd_busy after 255 halfwords -> 127 writes, then err_code=11, done pulse; the next sector is not issued.
- Second start pulse mid-transfer, then rst asserted mid-sector -> second start ignored; after reset all outputs 0; new start re-issues the first sector only after rd_busy=0.
- With SD_LOAD_SCHED_CHECKSUM_EN, 1 sector of halfwords 0x0000..0x00FF -> checksum equals the mod-2^32 sum of the 128 packed words.
